// File: rtl/div_dispatch.sv
`timescale 1ns/1ps
// div_dispatch: queues divide requests in a DEPTH-entry FIFO and hands them
// one at a time to an external iterative divider using a done/ready handshake.
// Requests with a zero divisor or zero divisor width are rejected without
// touching the divider and reported through out_err.
//   clk, rstn           : clock, asynchronous active-low reset
//   in_*                : request push interface (valid/ready)
//   div_done/div_q/...  : divider status and result inputs
//   div_ready/div_*     : divider start strobe and held operands
//   out_*               : one-cycle result strobe, no backpressure
module div_dispatch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  input  logic [4:0]  in_m,
  input  logic [4:0]  in_n,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_rem,
  input  logic [4:0]  div_num_add,
  input  logic [4:0]  div_num_sub,
  output logic        div_ready,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic [4:0]  div_m,
  output logic [4:0]  div_n,
  output logic        out_valid,
  output logic [31:0] out_q,
  output logic [31:0] out_rem,
  output logic [4:0]  out_num_add,
  output logic [4:0]  out_num_sub,
  output logic        out_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  m;
    logic [4:0]  n;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_ERR
  } state_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;

  logic            div_ready_q, div_ready_d;
  logic [31:0]     div_dividend_q, div_dividend_d;
  logic [31:0]     div_divisor_q, div_divisor_d;
  logic [4:0]      div_m_q, div_m_d;
  logic [4:0]      div_n_q, div_n_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_q_q, out_q_d;
  logic [31:0]     out_rem_q, out_rem_d;
  logic [4:0]      out_num_add_q, out_num_add_d;
  logic [4:0]      out_num_sub_q, out_num_sub_d;
  logic            out_err_q, out_err_d;

  logic            push;
  logic            pop;
  entry_t          in_entry;
  entry_t          head;
  logic            head_bad;

  assign in_ready = (count_q != FULL);
  assign push     = in_valid && in_ready;
  assign in_entry = '{dividend: in_dividend, divisor: in_divisor, m: in_m, n: in_n};
  assign head     = mem_q[rd_ptr_q];
  assign head_bad = (head.divisor == '0) || (head.n == '0);

  // FIFO storage and occupancy; pointers wrap naturally at AW bits.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Dispatch FSM. Rejection is checked before div_done so a bad head never
  // waits on the divider.
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    div_ready_d    = 1'b0;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    div_m_d        = div_m_q;
    div_n_d        = div_n_q;
    out_valid_d    = 1'b0;
    out_err_d      = 1'b0;
    out_q_d        = out_q_q;
    out_rem_d      = out_rem_q;
    out_num_add_d  = out_num_add_q;
    out_num_sub_d  = out_num_sub_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          if (head_bad) begin
            pop           = 1'b1;
            state_d       = S_ERR;
            out_valid_d   = 1'b1;
            out_err_d     = 1'b1;
            out_q_d       = '1;
            out_rem_d     = head.dividend;
            out_num_add_d = '0;
            out_num_sub_d = '0;
          end else if (div_done) begin
            pop            = 1'b1;
            state_d        = S_ISSUE;
            div_ready_d    = 1'b1;
            div_dividend_d = head.dividend;
            div_divisor_d  = head.divisor;
            div_m_d        = head.m;
            div_n_d        = head.n;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!div_done) begin
          state_d = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (div_done) begin
          state_d       = S_IDLE;
          out_valid_d   = 1'b1;
          out_q_d       = div_q;
          out_rem_d     = div_rem;
          out_num_add_d = div_num_add;
          out_num_sub_d = div_num_sub;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= S_IDLE;
      div_ready_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      div_m_q        <= '0;
      div_n_q        <= '0;
      out_valid_q    <= 1'b0;
      out_q_q        <= '0;
      out_rem_q      <= '0;
      out_num_add_q  <= '0;
      out_num_sub_q  <= '0;
      out_err_q      <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      div_ready_q    <= div_ready_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      div_m_q        <= div_m_d;
      div_n_q        <= div_n_d;
      out_valid_q    <= out_valid_d;
      out_q_q        <= out_q_d;
      out_rem_q      <= out_rem_d;
      out_num_add_q  <= out_num_add_d;
      out_num_sub_q  <= out_num_sub_d;
      out_err_q      <= out_err_d;
    end
  end

  assign div_ready    = div_ready_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;
  assign div_m        = div_m_q;
  assign div_n        = div_n_q;
  assign out_valid    = out_valid_q;
  assign out_q        = out_q_q;
  assign out_rem      = out_rem_q;
  assign out_num_add  = out_num_add_q;
  assign out_num_sub  = out_num_sub_q;
  assign out_err      = out_err_q;

endmodule

// File: tb/tb_div_dispatch.sv
`timescale 1ns/1ps
module tb_div_dispatch;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_dividend = '0;
  logic [31:0] in_divisor = '0;
  logic [4:0]  in_m = '0;
  logic [4:0]  in_n = '0;
  logic        div_done = 1'b1;
  logic [31:0] div_q = '0;
  logic [31:0] div_rem = '0;
  logic [4:0]  div_num_add = '0;
  logic [4:0]  div_num_sub = '0;
  logic        div_ready;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [4:0]  div_m;
  logic [4:0]  div_n;
  logic        out_valid;
  logic [31:0] out_q;
  logic [31:0] out_rem;
  logic [4:0]  out_num_add;
  logic [4:0]  out_num_sub;
  logic        out_err;

  always #5 clk = ~clk;

  div_dispatch #(.DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_m(in_m), .in_n(in_n),
    .div_done(div_done), .div_q(div_q), .div_rem(div_rem),
    .div_num_add(div_num_add), .div_num_sub(div_num_sub),
    .div_ready(div_ready), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_m(div_m), .div_n(div_n),
    .out_valid(out_valid), .out_q(out_q), .out_rem(out_rem),
    .out_num_add(out_num_add), .out_num_sub(out_num_sub), .out_err(out_err)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] rem;
    logic [4:0]  na;
    logic [4:0]  ns;
    logic        err;
  } res_t;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [4:0]  m;
    logic [4:0]  n;
  } req_t;

  res_t        exp_q[$];
  req_t        iss_q[$];
  logic [31:0] rec_q[$];
  logic [31:0] rec_rem[$];
  logic [4:0]  rec_na[$];
  logic [4:0]  rec_ns[$];
  logic        rec_err[$];

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int issue_cnt = 0;

  int          bfm_lat = 5;
  bit          hold_low = 1'b0;
  bit          bfm_busy = 1'b0;
  int          bfm_cnt = 0;
  bit          done_int = 1'b1;
  logic [31:0] bfm_a, bfm_b;

  res_t mon_e;
  req_t mon_r;

  // Divider's reported step counts: arbitrary but fixed functions of operands.
  function automatic logic [4:0] add_cnt(input logic [31:0] a);
    return 5'(a % 29);
  endfunction

  function automatic logic [4:0] sub_cnt(input logic [31:0] b);
    return 5'(b % 31);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference divider: sees the start strobe, drops done, then returns the
  // quotient/remainder with done high after bfm_lat cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        bfm_busy = 1'b0;
        bfm_cnt  = 0;
        done_int = 1'b1;
      end else if (bfm_busy) begin
        chk("no_issue_while_busy", 32'(div_ready), 32'd0);
        bfm_cnt++;
        if (bfm_cnt == 1) begin
          done_int = 1'b0;
        end else if (bfm_cnt >= bfm_lat) begin
          div_q       = (bfm_b == 0) ? '1 : bfm_a / bfm_b;
          div_rem     = (bfm_b == 0) ? '0 : bfm_a % bfm_b;
          div_num_add = add_cnt(bfm_a);
          div_num_sub = sub_cnt(bfm_b);
          done_int    = 1'b1;
          bfm_busy    = 1'b0;
        end
      end else if (div_ready) begin
        bfm_a    = div_dividend;
        bfm_b    = div_divisor;
        bfm_busy = 1'b1;
        bfm_cnt  = 0;
      end
      div_done = done_int && !hold_low;
    end
  end

  // Compare process: every issue and every result against the model queues.
  always @(negedge clk) begin
    if (rstn && div_ready) begin
      issue_cnt++;
      if (iss_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: dividend %0h divisor %0h", div_dividend, div_divisor);
      end else begin
        mon_r = iss_q.pop_front();
        chk("div_dividend", div_dividend, mon_r.dvd);
        chk("div_divisor", div_divisor, mon_r.dvs);
        chk("div_m", 32'(div_m), 32'(mon_r.m));
        chk("div_n", 32'(div_n), 32'(mon_r.n));
      end
    end
    if (rstn && out_valid) begin
      out_cnt++;
      rec_q.push_back(out_q);
      rec_rem.push_back(out_rem);
      rec_na.push_back(out_num_add);
      rec_ns.push_back(out_num_sub);
      rec_err.push_back(out_err);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: q %0h rem %0h err %0b", out_q, out_rem, out_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_q", out_q, mon_e.q);
        chk("out_rem", out_rem, mon_e.rem);
        chk("out_num_add", 32'(out_num_add), 32'(mon_e.na));
        chk("out_num_sub", 32'(out_num_sub), 32'(mon_e.ns));
        chk("out_err", 32'(out_err), 32'(mon_e.err));
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] m, input logic [4:0] n, input bit exp_acc);
    res_t r;
    req_t q;
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    in_m        = m;
    in_n        = n;
    chk("in_ready", 32'(in_ready), 32'(exp_acc));
    if (exp_acc) begin
      if (b == 0 || n == 0) begin
        r = '{q: 32'hFFFF_FFFF, rem: a, na: 5'd0, ns: 5'd0, err: 1'b1};
      end else begin
        r = '{q: a / b, rem: a % b, na: add_cnt(a), ns: sub_cnt(b), err: 1'b0};
        q = '{dvd: a, dvs: b, m: m, n: n};
        iss_q.push_back(q);
      end
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int target, input int budget);
    int n = 0;
    while (out_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (out_cnt < target) begin
      errors++;
      $display("FAIL wait_outs: got %0d results expected %0d", out_cnt, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, ibase, n;

    // Reset values
    #23;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_div_ready", 32'(div_ready), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_q", out_q, 32'd0);
    chk("rst_div_dividend", div_dividend, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_output", 32'(out_cnt), 32'd0);

    // Single request with latency pin
    base  = out_cnt;
    ibase = issue_cnt;
    push(32'd7, 32'd2, 5'd3, 5'd2, 1'b1);
    @(negedge clk);
    chk("lat_ready_e1", 32'(div_ready), 32'd0);
    @(negedge clk);
    chk("lat_ready_e2", 32'(div_ready), 32'd1);
    wait_outs(base + 1, 60);
    chk("t1_issues", 32'(issue_cnt - ibase), 32'd1);
    chk("t1_q", rec_q[base], 32'd3);
    chk("t1_rem", rec_rem[base], 32'd1);
    chk("t1_err", 32'(rec_err[base]), 32'd0);

    // Back-to-back ordering
    base  = out_cnt;
    ibase = issue_cnt;
    push(32'd100, 32'd17, 5'd7, 5'd5, 1'b1);
    push(32'd256, 32'd33, 5'd9, 5'd6, 1'b1);
    push(32'd53, 32'd65, 5'd6, 5'd7, 1'b1);
    wait_outs(base + 3, 200);
    chk("t2_issues", 32'(issue_cnt - ibase), 32'd3);
    chk("t2_q0", rec_q[base], 32'd5);
    chk("t2_r0", rec_rem[base], 32'd15);
    chk("t2_q1", rec_q[base + 1], 32'd7);
    chk("t2_r1", rec_rem[base + 1], 32'd25);
    chk("t2_q2", rec_q[base + 2], 32'd0);
    chk("t2_r2", rec_rem[base + 2], 32'd53);

    // Rejected request followed by a normal one
    base  = out_cnt;
    ibase = issue_cnt;
    push(32'd45, 32'd0, 5'd6, 5'd1, 1'b1);
    push(32'd7, 32'd2, 5'd3, 5'd2, 1'b1);
    wait_outs(base + 2, 100);
    chk("t3_issues", 32'(issue_cnt - ibase), 32'd1);
    chk("t3_err", 32'(rec_err[base]), 32'd1);
    chk("t3_q", rec_q[base], 32'hFFFF_FFFF);
    chk("t3_rem", rec_rem[base], 32'd45);
    chk("t3_na", 32'(rec_na[base]), 32'd0);
    chk("t3_ns", 32'(rec_ns[base]), 32'd0);
    chk("t3_next_err", 32'(rec_err[base + 1]), 32'd0);
    chk("t3_next_q", rec_q[base + 1], 32'd3);

    // Full FIFO with the divider held busy
    base  = out_cnt;
    ibase = issue_cnt;
    hold_low = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      push(32'(10 + 3 * i), 32'd3, 5'd5, 5'd2, (i < 4));
    end
    repeat (5) @(negedge clk);
    chk("t4_no_out_held", 32'(out_cnt - base), 32'd0);
    chk("t4_in_ready_full", 32'(in_ready), 32'd0);
    hold_low = 1'b0;
    wait_outs(base + 4, 300);
    repeat (40) @(negedge clk);
    chk("t4_drained", 32'(out_cnt - base), 32'd4);
    chk("t4_issues", 32'(issue_cnt - ibase), 32'd4);
    chk("t4_last_q", rec_q[base + 3], 32'd6);
    chk("t4_last_rem", rec_rem[base + 3], 32'd1);

    // Reset while waiting on the divider with two requests queued
    bfm_lat = 30;
    push(32'd200, 32'd7, 5'd8, 5'd3, 1'b1);
    n = 0;
    while (!(bfm_busy && bfm_cnt >= 3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_wait", 32'(bfm_busy && bfm_cnt >= 3), 32'd1);
    push(32'd9, 32'd4, 5'd4, 5'd3, 1'b1);
    push(32'd11, 32'd5, 5'd4, 5'd3, 1'b1);
    base = out_cnt;
    @(negedge clk);
    #2 rstn = 1'b0;
    exp_q.delete();
    iss_q.delete();
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_div_ready", 32'(div_ready), 32'd0);
    chk("t5_rst_out_err", 32'(out_err), 32'd0);
    chk("t5_rst_out_q", out_q, 32'd0);
    chk("t5_rst_out_rem", out_rem, 32'd0);
    chk("t5_rst_out_na", 32'(out_num_add), 32'd0);
    chk("t5_rst_div_dividend", div_dividend, 32'd0);
    chk("t5_rst_div_divisor", div_divisor, 32'd0);
    chk("t5_rst_div_m", 32'(div_m), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    bfm_lat = 5;
    repeat (40) @(negedge clk);
    chk("t5_abandoned", 32'(out_cnt - base), 32'd0);
    push(32'd7, 32'd2, 5'd3, 5'd2, 1'b1);
    wait_outs(base + 1, 60);
    chk("t5_fresh_q", rec_q[base], 32'd3);
    chk("t5_fresh_rem", rec_rem[base], 32'd1);
    repeat (10) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_dispatch.md
DIV_DISPATCH -- requirements
Module: div_dispatch

Interface
REQ-001 Parameter: DEPTH, default 4, number of request-FIFO entries (power of two, at least 2).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rstn  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 in_valid  in  1  request present on in_* this cycle.
REQ-005 in_ready  out  1  FIFO not full; a request is pushed when in_valid and in_ready are both high at a rising edge.
REQ-006 in_dividend / in_divisor  in  32 / 32  request operands.
REQ-007 in_m / in_n  in  5 / 5  significant bit widths of dividend and divisor.
REQ-008 div_done  in  1  divider idle/result-valid flag.
REQ-009 div_q / div_rem  in  32 / 32  divider quotient and remainder.
REQ-010 div_num_add / div_num_sub  in  5 / 5  divider add and subtract counts.
REQ-011 div_ready  out  1  start strobe to the divider.
REQ-012 div_dividend / div_divisor  out  32 / 32  operands to the divider.
REQ-013 div_m / div_n  out  5 / 5  operand widths to the divider.
REQ-014 out_valid  out  1  one-cycle result strobe; there is no backpressure.
REQ-015 out_q / out_rem  out  32 / 32  result.
REQ-016 out_num_add / out_num_sub  out  5 / 5  result counts.
REQ-017 out_err  out  1  request rejected (divisor==0 or n==0); qualified by out_valid.

Function
REQ-018 FIFO: DEPTH entries of {dividend, divisor, m, n}; in_ready = (count != DEPTH), driven from registered count.
REQ-019 FIFO: push and pop in the same cycle leave count unchanged.
REQ-020 FIFO: a push while full is ignored, and entry contents are unchanged.
REQ-021 FIFO: pointers wrap modulo DEPTH.
REQ-022 FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, ERR.
REQ-023 IDLE -> ERR when count != 0 and the head entry has divisor == 0 or n == 0; the head is popped on that transition; this transition is independent of div_done.
REQ-024 IDLE -> ISSUE when count != 0, the head entry is valid, and div_done == 1; the head is popped and latched into the div_* operand registers on that transition.
REQ-025 ISSUE lasts exactly one cycle with div_ready = 1, then goes to WAIT_LOW.
REQ-026 div_ready is 0 in every other state.
REQ-027 WAIT_LOW -> WAIT_HIGH on the first cycle div_done == 0.
REQ-028 WAIT_HIGH -> IDLE on the first cycle div_done == 1.
REQ-029 On the WAIT_HIGH -> IDLE transition, out_q/out_rem/out_num_add/out_num_sub are registered from div_*, and out_valid = 1 and out_err = 0 for the next cycle.
REQ-030 ERR lasts one cycle: out_valid = 1, out_err = 1, out_q = 32'hFFFFFFFF, out_rem = rejected dividend, counts = 0; then goes to IDLE.
REQ-031 div_dividend/div_divisor/div_m/div_n hold stable from ISSUE until the next pop.
REQ-032 Latency, empty FIFO and idle divider: push at edge E0 -> div_ready high in the cycle after E1 -> out_valid the cycle after the edge sampling div_done rising.
REQ-033 Requests complete strictly in FIFO order, and at most one request is in flight.
REQ-034 div_done activity seen in IDLE, ISSUE or ERR is ignored and produces no output.
REQ-035 out_valid is low at all times other than those defined in REQ-029 and REQ-030.

Reset
REQ-036 On rstn low, immediately: FIFO emptied (count = 0, pointers 0), FSM = IDLE.
REQ-037 On rstn low, immediately: div_ready = 0, out_valid = 0, out_err = 0.
REQ-038 On rstn low, immediately: all data outputs = 0.
REQ-039 Reset during WAIT_LOW/WAIT_HIGH abandons the in-flight result.
REQ-040 After reset, no request is issued until div_done == 1.

Verification
REQ-041 Push {7, 2, m=3, n=2}, divider idle -> exactly one div_ready pulse; out_valid with q = 3, rem = 1, out_err = 0.
REQ-042 Push back-to-back {100, 17, 7, 5}, {256, 33, 9, 6}, {53, 65, 6, 7} -> three out_valid pulses in order: q/rem = 5/15, 7/25, 0/53; never two div_ready pulses without an intervening div_done low.
REQ-043 Push {45, 0, 6, 1} -> no div_ready pulse; one out_valid with out_err = 1, q = FFFFFFFF, rem = 45, counts 0; the following request issues normally.
REQ-044 Hold div_done = 0 and push 5 requests -> in_ready drops after the 4th; 5th is dropped; releasing div_done drains exactly 4 results.
REQ-045 Assert rstn low in WAIT_HIGH with 2 entries queued -> outputs cleared immediately; no out_valid for the abandoned or queued requests; a fresh push completes normally.
